// File: rtl/pulse_pkg.sv
// pulse_pkg: shared FSM state, default thresholds and saturating increment for pulse_meter. Rev 1.0
`default_nettype none

package pulse_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  // Shared with the strobe generator so both sides agree on the loss threshold.
  localparam logic [31:0] C_TIMEOUT_DEFAULT    = 32'h019bfcc0;
  localparam int unsigned C_FILTER_LEN_DEFAULT = 4;

  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_value);
    return (value >= max_value) ? value : value + 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_meter_sync.sv
// pulse_meter_sync: synchronizer for pulse_in with optional glitch filter
// (PULSE_METER_GLITCH_FILTER_EN). Rev 1.0
`default_nettype none

module pulse_meter_sync
  import pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = C_FILTER_LEN_DEFAULT
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic pulse_i,
  output logic s_in_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1) begin : g_param_check
    $error("pulse_meter_sync: illegal SYNC_STAGES or FILTER_LEN");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
    end
  end

`ifdef PULSE_METER_GLITCH_FILTER_EN
  localparam int unsigned RUN_W = $clog2(FILTER_LEN + 1);

  logic [RUN_W-1:0] run_q;
  logic             filt_q;

  // Output flips on the FILTER_LEN-th consecutive sample that disagrees with it.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      run_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      run_q <= '0;
    end else if (run_q == RUN_W'(FILTER_LEN - 1)) begin
      run_q  <= '0;
      filt_q <= sync_q[SYNC_STAGES-1];
    end else begin
      run_q <= run_q + RUN_W'(1);
    end
  end

  assign s_in_o = filt_q;
`else
  assign s_in_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

`default_nettype wire

// File: rtl/pulse_meter.sv
// pulse_meter: measures high width and rise-to-rise period of a pulse train, flags loss of signal.
// Optional glitch filter: define PULSE_METER_GLITCH_FILTER_EN. Rev 1.0
`default_nettype none

module pulse_meter
  import pulse_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TIMEOUT     = WIDTH'(C_TIMEOUT_DEFAULT),
  parameter int unsigned      FILTER_LEN  = C_FILTER_LEN_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pulse_in,
  output logic             valid,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] width,
  output logic             timeout,
  output logic             active,
  output logic [15:0]      pulse_count
);

  localparam logic [63:0] CNT_MAX = (64'd1 << WIDTH) - 64'd1;

  if (TIMEOUT == {WIDTH{1'b1}}) begin : g_timeout_check
    $error("pulse_meter: TIMEOUT must be below the counter saturation value");
  end

  logic             s_in;
  logic             s_prev_q;
  logic             rise;
  state_e           state_q;
  logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [WIDTH-1:0] width_cnt_q, width_cnt_d;
  logic [WIDTH-1:0] pend_period_q, pend_width_q;
  logic [WIDTH-1:0] period_q, width_q;
  logic             pend_q, valid_q, timeout_q, active_q;
  logic [15:0]      count_q;

  pulse_meter_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .pulse_i   (pulse_in),
    .s_in_o    (s_in)
  );

  assign rise         = s_in & ~s_prev_q;
  assign period_cnt_d = WIDTH'(sat_inc(64'(period_cnt_q), CNT_MAX));
  assign width_cnt_d  = WIDTH'(sat_inc(64'(width_cnt_q), CNT_MAX));

  // A measured rise is staged in pend_* and published with valid one cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      s_prev_q      <= 1'b0;
      period_cnt_q  <= '0;
      width_cnt_q   <= '0;
      pend_period_q <= '0;
      pend_width_q  <= '0;
      period_q      <= '0;
      width_q       <= '0;
      pend_q        <= 1'b0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
      active_q      <= 1'b0;
      count_q       <= '0;
    end else begin
      s_prev_q  <= s_in;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (!enable) begin
        state_q      <= IDLE;
        active_q     <= 1'b0;
        period_cnt_q <= '0;
        width_cnt_q  <= '0;
      end else begin
        if (pend_q) begin
          valid_q  <= 1'b1;
          period_q <= pend_period_q;
          width_q  <= pend_width_q;
          count_q  <= count_q + 16'd1;
        end
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q      <= MEASURE;
              active_q     <= 1'b1;
              period_cnt_q <= WIDTH'(1);
              width_cnt_q  <= WIDTH'(1);
            end
          end
          MEASURE: begin
            if (rise) begin
              pend_q        <= 1'b1;
              pend_period_q <= period_cnt_q;
              pend_width_q  <= width_cnt_q;
              period_cnt_q  <= WIDTH'(1);
              width_cnt_q   <= WIDTH'(1);
            end else if (period_cnt_q == TIMEOUT) begin
              timeout_q    <= 1'b1;
              state_q      <= IDLE;
              active_q     <= 1'b0;
              period_cnt_q <= '0;
              width_cnt_q  <= '0;
            end else begin
              period_cnt_q <= period_cnt_d;
              if (s_in) begin
                width_cnt_q <= width_cnt_d;
              end
            end
          end
          default: begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign valid       = valid_q;
  assign period      = period_q;
  assign width       = width_q;
  assign timeout     = timeout_q;
  assign active      = active_q;
  assign pulse_count = count_q;

endmodule

`default_nettype wire
